mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
// - MEM pipeline stage: consumes ex_mem outputs, drives mem_wb inputs (mem_wd/mem_wreg/mem_wdata).
// - Non-memory ops pass through in the same cycle (0 latency).
// - LB/LBU/LH/LHU/LW/SB/SH/SW run a multi-cycle data-bus transaction with req/ack handshake.
// - Raises stallreq while busy; signals timeout and misalignment on bus_err.
// PARAMETERS
// - TIMEOUT  16  max BUSY cycles without bus_ack before abort (>=2); counter width $clog2(TIMEOUT+1)
// PORTS
// - clk        in   1   clock, all state on posedge
// - rst        in   1   synchronous, active-high reset (rst == `RstEnable)
// - ex_wd      in   5   dest reg addr (`RegAddrBus)
// - ex_wreg    in   1   dest write enable
// - ex_wdata   in   32  ALU result (`RegBus)
// - ex_aluop   in   8   op code (`AluOpBus)
// - ex_addr    in   32  effective byte address
// - ex_sdata   in   32  store data (rt)
// - bus_rdata  in   32  read data, valid when bus_ack=1
// - bus_ack    in   1   transaction complete
// - mem_wd     out  5   to mem_wb
// - mem_wreg   out  1   to mem_wb
// - mem_wdata  out  32  to mem_wb
// - bus_req    out  1   registered request
// - bus_we     out  1   registered; 1=store
// - bus_addr   out  32  registered; word-aligned ({ex_addr[31:2],2'b00})
// - bus_sel    out  4   registered byte enables, big-endian: addr[1:0]=00 -> 4'b1000
// - bus_wdata  out  32  registered; store byte/half replicated to all lanes
// - stallreq   out  1   to pipeline ctrl; holds ex_mem stable
// - bus_err    out  1   one-cycle pulse: timeout or misaligned access
// BEHAVIOUR
// - Reset: state=IDLE, count=0, bus_req/bus_we=0, bus_addr/bus_wdata=`ZeroWord, bus_sel=0, bus_err=0.
//   Combinational outputs in reset: mem_wd=`NOPRegAddr, mem_wreg=`WriteDisable, mem_wdata=`ZeroWord,
//   stallreq=0. Reset mid-transaction drops bus_req at the next edge; no write issued.
// - FSM IDLE -> BUSY -> DONE -> IDLE.
// - IDLE, non-mem op: mem_* = ex_* combinationally, stallreq=0.
// - IDLE, mem op, aligned: stallreq=1, mem_wreg=0. Register bus_*; -> BUSY.
// - IDLE, mem op, misaligned (half: addr[0]=1; word: addr[1:0]!=0): no bus cycle,
//   mem_wreg=0, stallreq=1, -> DONE with err flag.
// - BUSY: bus_req=1, bus_* held, stallreq=1, mem_wreg=0 (bubble into mem_wb), count++.
//   - bus_ack=1: capture bus_rdata; bus_req=0 at edge; -> DONE.
//   - count==TIMEOUT-1 and no ack: bus_req=0, -> DONE with err flag.
// - DONE: stallreq=0, bus_err=err flag.
//   - Load without err: mem_wreg=ex_wreg, mem_wd=ex_wd, mem_wdata=extended lane (LB/LH sign-extend,
//     LBU/LHU zero-extend).
//   - Store or err: mem_wreg=0.
//   - -> IDLE; next op is evaluated fresh (back-to-back mem ops are legal).
// - Loads occupy >=3 cycles: stallreq high 2 cycles with ack in the first BUSY cycle.
// - bus_ack outside BUSY is ignored; bus_ack in the same cycle as the timeout wins (no err).
// STRUCTURE
// - define.v: EXE_LB_OP 8'hE0, EXE_LBU_OP 8'hE4, EXE_LH_OP 8'hE1, EXE_LHU_OP 8'hE5, EXE_LW_OP 8'hE3,
//   EXE_SB_OP 8'hE8, EXE_SH_OP 8'hE9, EXE_SW_OP 8'hEB; state encodings MEM_IDLE/MEM_BUSY/MEM_DONE.
// - Sub-module mem_align (combinational): aluop+addr[1:0] -> bus_sel, store lane replication,
//   misalign flag, load extraction/extension.
// TESTING
// - Add, ex_wdata=32'h1234, ex_wd=5, ex_wreg=1 -> same cycle mem_wdata=32'h1234, mem_wd=5, stallreq=0.
// - LB, addr=32'h103, bus_rdata=32'h000000F0, ack 1st BUSY cycle -> bus_sel=4'b0001,
//   DONE mem_wdata=32'hFFFFFFF0, mem_wreg=1; stallreq high exactly 2 cycles.
// - SH, addr=32'h202, sdata=32'hABCD -> bus_we=1, bus_sel=4'b0011, bus_wdata=32'hABCDABCD,
//   mem_wreg=0 in every cycle.
// - LW, addr=32'h6 -> no bus_req, bus_err pulse in DONE, mem_wreg=0.
// - LW, TIMEOUT=4, no ack -> bus_req high 4 cycles, then bus_err=1, mem_wreg=0, back to IDLE.
// - rst=1 during BUSY -> next edge bus_req=0, state IDLE, stallreq=0; a late bus_ack is ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the MEM stage.
package mem_access_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;

  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

  function automatic logic is_load_op(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return is_load_op(op) | is_store_op(op);
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Byte-lane logic for the MEM stage: big-endian byte enables, store lane
// replication, misalignment detection and load extraction/extension.
module mem_access_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // Big-endian: byte address 0 lives in the most significant lane
    case (addr_lo)
      2'd0:    byte_lane = rdata[31:24];
      2'd1:    byte_lane = rdata[23:16];
      2'd2:    byte_lane = rdata[15:8];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    sel       = 4'b0000;
    wdata     = ZERO_WORD;
    misalign  = 1'b0;
    load_data = ZERO_WORD;

    case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        sel   = 4'b1000 >> addr_lo;
        wdata = {4{sdata[7:0]}};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        sel      = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata    = {2{sdata[15:0]}};
        misalign = addr_lo[0];
      end
      EXE_LW_OP, EXE_SW_OP: begin
        sel      = 4'b1111;
        wdata    = sdata;
        misalign = |addr_lo;
      end
      default: ;
    endcase

    case (aluop)
      EXE_LB_OP:  load_data = {{24{byte_lane[7]}}, byte_lane};
      EXE_LBU_OP: load_data = {24'h0, byte_lane};
      EXE_LH_OP:  load_data = {{16{half_lane[15]}}, half_lane};
      EXE_LHU_OP: load_data = {16'h0, half_lane};
      EXE_LW_OP:  load_data = rdata;
      default:    load_data = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: non-memory ops pass straight through, loads/stores run a
// req/ack bus transaction with timeout and stall the pipeline while busy.
//
//   state    | meaning
//   MEM_IDLE | evaluate ex_* op; pass through or launch/abort a bus access
//   MEM_BUSY | bus_req asserted, waiting for bus_ack or timeout
//   MEM_DONE | result slot: load writeback or bubble; bus_err pulses here
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_sdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  output logic        stallreq,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_t    state, state_nxt;
  logic [CW-1:0] count;
  logic [31:0]   rdata_q;
  logic          err_nxt;
  logic          mem_op;
  logic          a_misalign;
  logic [3:0]    a_sel;
  logic [31:0]   a_wdata;
  logic [31:0]   a_load;

  assign mem_op = is_mem_op(ex_aluop);

  mem_access_align u_align (
    .aluop     (ex_aluop),
    .addr_lo   (ex_addr[1:0]),
    .sdata     (ex_sdata),
    .rdata     (rdata_q),
    .sel       (a_sel),
    .wdata     (a_wdata),
    .misalign  (a_misalign),
    .load_data (a_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MEM_IDLE;
      count     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= ZERO_WORD;
      bus_sel   <= 4'b0000;
      bus_wdata <= ZERO_WORD;
      bus_err   <= 1'b0;
      rdata_q   <= ZERO_WORD;
    end else begin
      state   <= state_nxt;
      bus_err <= (state_nxt == MEM_DONE) && err_nxt;
      case (state)
        MEM_IDLE: begin
          count <= '0;
          if (mem_op && !a_misalign) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store_op(ex_aluop);
            bus_addr  <= {ex_addr[31:2], 2'b00};
            bus_sel   <= a_sel;
            bus_wdata <= a_wdata;
          end
        end
        MEM_BUSY: begin
          count <= count + CW'(1);
          if (bus_ack) rdata_q <= bus_rdata;
          if (state_nxt != MEM_BUSY) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
          end
        end
        default: count <= '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    stallreq  = 1'b0;
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_wdata = ex_wdata;

    case (state)
      MEM_IDLE: begin
        if (mem_op) begin
          stallreq  = 1'b1;
          mem_wd    = NOP_REG_ADDR;
          mem_wreg  = 1'b0;
          mem_wdata = ZERO_WORD;
          if (a_misalign) begin
            state_nxt = MEM_DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = MEM_BUSY;
          end
        end
      end
      MEM_BUSY: begin
        stallreq  = 1'b1;
        mem_wd    = NOP_REG_ADDR;
        mem_wreg  = 1'b0;
        mem_wdata = ZERO_WORD;
        // An ack arriving on the last allowed cycle still completes cleanly
        if (bus_ack) begin
          state_nxt = MEM_DONE;
        end else if (count == CW'(TIMEOUT - 1)) begin
          state_nxt = MEM_DONE;
          err_nxt   = 1'b1;
        end
      end
      MEM_DONE: begin
        state_nxt = MEM_IDLE;
        if (is_load_op(ex_aluop) && !bus_err) begin
          mem_wdata = a_load;
        end else begin
          mem_wd    = NOP_REG_ADDR;
          mem_wreg  = 1'b0;
          mem_wdata = ZERO_WORD;
        end
      end
      default: state_nxt = MEM_IDLE;
    endcase

    if (rst) begin
      stallreq  = 1'b0;
      mem_wd    = NOP_REG_ADDR;
      mem_wreg  = 1'b0;
      mem_wdata = ZERO_WORD;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized ops
// against a transaction-level reference model.
module tb_mem_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_addr;
  logic [31:0] ex_sdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        stallreq;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_aluop  (ex_aluop),
    .ex_addr   (ex_addr),
    .ex_sdata  (ex_sdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_sel   (bus_sel),
    .bus_wdata (bus_wdata),
    .stallreq  (stallreq),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes (0 = not a memory op)
  function automatic int op_size(input logic [7:0] op);
    case (op)
      8'hE0, 8'hE4, 8'hE8: return 1;
      8'hE1, 8'hE5, 8'hE9: return 2;
      8'hE3, 8'hEB:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit op_is_load(input logic [7:0] op);
    return (op == 8'hE0) || (op == 8'hE4) || (op == 8'hE1) || (op == 8'hE5) || (op == 8'hE3);
  endfunction

  function automatic bit op_signed(input logic [7:0] op);
    return (op == 8'hE0) || (op == 8'hE1);
  endfunction

  function automatic logic [3:0] model_sel(input int size, input int a);
    int m;
    m = ((1 << size) - 1) << (4 - size - a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int size, input logic [31:0] sd);
    logic [31:0] r;
    r = sd;
    if (size == 1) r = {4{sd[7:0]}};
    if (size == 2) r = {2{sd[15:0]}};
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input int a, input logic [31:0] rd);
    int size;
    logic [31:0] mask, v;
    size = op_size(op);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v = (rd >> (8 * (4 - size - a))) & mask;
    if (op_signed(op) && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  // Drive one op (starting just after a posedge) and check every cycle until it retires.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] wdat, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] rd, input int ack_delay);
    int  size, a, n, stall_cnt;
    bit  acked, err;
    size = op_size(op);
    a    = int'(addr[1:0]);
    ex_aluop = op; ex_addr = addr; ex_sdata = sd;
    ex_wdata = wdat; ex_wd = wd; ex_wreg = wreg;
    if (size == 0) begin
      bus_ack   = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      #1;
      check_eq("pass_wdata", mem_wdata, wdat);
      check_eq("pass_wd", 32'(mem_wd), 32'(wd));
      check_eq("pass_wreg", 32'(mem_wreg), 32'(wreg));
      check_eq("pass_stall", 32'(stallreq), 32'(0));
      @(posedge clk); #1;
      bus_ack = 1'b0;
      check_eq("idle_no_req", 32'(bus_req), 32'(0));
      return;
    end
    #1;
    check_eq("issue_stall", 32'(stallreq), 32'(1));
    check_eq("issue_wreg", 32'(mem_wreg), 32'(0));
    stall_cnt = 1;
    @(posedge clk); #1;
    n = 0;
    acked = 1'b0;
    if ((a % size) == 0) begin
      while (!acked && n < TMO) begin
        bus_ack   = (n == ack_delay);
        bus_rdata = bus_ack ? rd : $urandom;
        #1;
        check_eq("busy_req", 32'(bus_req), 32'(1));
        check_eq("busy_we", 32'(bus_we), 32'(!op_is_load(op)));
        check_eq("busy_addr", bus_addr, {addr[31:2], 2'b00});
        check_eq("busy_sel", 32'(bus_sel), 32'(model_sel(size, a)));
        if (!op_is_load(op)) check_eq("busy_wdata", bus_wdata, model_wdata(size, sd));
        check_eq("busy_wreg", 32'(mem_wreg), 32'(0));
        if (stallreq) stall_cnt++;
        acked = bus_ack;
        n++;
        @(posedge clk); #1;
        bus_ack = 1'b0;
      end
    end
    err = !acked;
    #1;
    check_eq("done_req", 32'(bus_req), 32'(0));
    check_eq("done_err", 32'(bus_err), 32'(err));
    check_eq("done_stall", 32'(stallreq), 32'(0));
    check_eq("stall_cycles", 32'(stall_cnt), 32'(1 + n));
    if (op_is_load(op) && !err) begin
      check_eq("done_wreg", 32'(mem_wreg), 32'(wreg));
      check_eq("done_wd", 32'(mem_wd), 32'(wd));
      check_eq("done_load", mem_wdata, model_load(op, a, rd));
    end else begin
      check_eq("done_wreg0", 32'(mem_wreg), 32'(0));
    end
    @(posedge clk); #1;
    check_eq("after_err_clear", 32'(bus_err), 32'(0));
  endtask

  logic [7:0] mem_ops [8];

  initial begin
    mem_ops = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};
    rst = 1'b1;
    ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234; ex_aluop = 8'h20;
    ex_addr = 32'h0; ex_sdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(bus_req), 32'(0));
    check_eq("rst_we", 32'(bus_we), 32'(0));
    check_eq("rst_addr", bus_addr, 32'h0);
    check_eq("rst_sel", 32'(bus_sel), 32'(0));
    check_eq("rst_wdata_bus", bus_wdata, 32'h0);
    check_eq("rst_err", 32'(bus_err), 32'(0));
    check_eq("rst_stall", 32'(stallreq), 32'(0));
    check_eq("rst_wd", 32'(mem_wd), 32'(0));
    check_eq("rst_wreg", 32'(mem_wreg), 32'(0));
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Directed cases
    run_op(8'h20, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 32'h0, 0);
    run_op(8'hE0, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1, 32'h0000_00F0, 0);
    run_op(8'hE9, 32'h202, 32'hABCD, 32'h0, 5'd3, 1'b1, 32'h0, 1);
    run_op(8'hE3, 32'h6, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0, 0);
    run_op(8'hE3, 32'h10, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0, TMO + 2);
    run_op(8'hE3, 32'h14, 32'h0, 32'h0, 5'd9, 1'b1, 32'hCAFE_F00D, TMO - 1);
    run_op(8'hE8, 32'h0, 32'h5A, 32'h0, 5'd1, 1'b1, 32'h0, 0);
    run_op(8'hE4, 32'h101, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0080_0000, 0);

    // Reset while busy
    ex_aluop = 8'hE3; ex_addr = 32'h40; ex_wd = 5'd6; ex_wreg = 1'b1;
    @(posedge clk); #1;
    check_eq("rb_req", 32'(bus_req), 32'(1));
    rst = 1'b1;
    #1;
    check_eq("rb_stall_in_rst", 32'(stallreq), 32'(0));
    check_eq("rb_wreg_in_rst", 32'(mem_wreg), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    ex_aluop = 8'h21; ex_wdata = 32'h7777; ex_wd = 5'd8; ex_wreg = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("rb_req_dropped", 32'(bus_req), 32'(0));
    check_eq("rb_idle_stall", 32'(stallreq), 32'(0));
    check_eq("rb_pass_wdata", mem_wdata, 32'h7777);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check_eq("rb_late_ack_req", 32'(bus_req), 32'(0));
    check_eq("rb_late_ack_err", 32'(bus_err), 32'(0));

    // Randomized ops
    for (int i = 0; i < 250; i++) begin
      logic [7:0] op;
      if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 8'hDF));
      else op = mem_ops[$urandom_range(0, 7)];
      run_op(op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
             $urandom, int'($urandom_range(0, TMO + 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
